// File: rtl/param_sap_cpu.sv
// Parametrised SAP-style CPU: muxed datapath, internal RAM, program-load port, fetch/execute FSM.
// Optional feature macro: SINGLE_STEP_EN adds a synchronised step input that gates each instruction at T0.
module param_sap_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SINGLE_STEP_EN
    input  logic              step_i,
`endif
    input  logic              run_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [DATA_W-1:0] prog_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              halted_o,
    output logic              cf_o,
    output logic              zf_o,
    output logic [ADDR_W-1:0] pc_dbg_o,
    output logic [2:0]        state_dbg_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
        S_T3   = 3'd4, S_T4 = 3'd5, S_HALT = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                           OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                           OP_OUT = 4'hE, OP_HLT = 4'hF;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q, mar_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q, out_q;
    logic              out_valid_q, cf_q, zf_q;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   alu_d;
    logic              step_go;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];

`ifdef SINGLE_STEP_EN
    // Two flops synchronise step_i; the third holds the previous value for edge detection.
    logic [2:0] step_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_sync_q <= '0;
        else        step_sync_q <= {step_sync_q[1:0], step_i};
    end

    assign step_go = step_sync_q[1] & ~step_sync_q[2];
`else
    assign step_go = 1'b1;
`endif

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        alu_d = '0;
        if (opcode == OP_SUB)
            alu_d = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
        else
            alu_d = {1'b0, a_q} + {1'b0, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cf_q        <= 1'b0;
            zf_q        <= 1'b0;
            // NOTE: the RAM must clear on reset, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    pc_q <= '0;
                    if (prog_we_i) ram_q[prog_addr_i] <= prog_data_i;
                    if (run_i) state_q <= S_T0;
                end
                S_T0: begin
                    if (step_go) begin
                        mar_q   <= pc_q;
                        state_q <= S_T1;
                    end else if (!run_i) begin
                        state_q <= S_IDLE;
                        pc_q    <= '0;
                    end
                end
                S_T1: begin
                    ir_q    <= ram_q[mar_q];
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_T2;
                end
                S_T2: begin
                    if (opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA}) begin
                        mar_q   <= operand;
                        state_q <= S_T3;
                    end else if (opcode == OP_HLT) begin
                        state_q <= S_HALT;
                    end else begin
                        case (opcode)
                            OP_LDI: a_q <= {{(DATA_W-ADDR_W){1'b0}}, operand};
                            OP_JMP: pc_q <= operand;
                            OP_JC:  if (cf_q) pc_q <= operand;
                            OP_JZ:  if (zf_q) pc_q <= operand;
                            OP_OUT: begin
                                out_q       <= a_q;
                                out_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                        // Instruction boundary: a dropped run overrides any jump target.
                        state_q <= run_i ? S_T0 : S_IDLE;
                        if (!run_i) pc_q <= '0;
                    end
                end
                S_T3: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        b_q     <= ram_q[mar_q];
                        state_q <= S_T4;
                    end else begin
                        if (opcode == OP_LDA) a_q <= ram_q[mar_q];
                        else                  ram_q[mar_q] <= a_q;
                        state_q <= run_i ? S_T0 : S_IDLE;
                        if (!run_i) pc_q <= '0;
                    end
                end
                S_T4: begin
                    {cf_q, a_q} <= alu_d;
                    zf_q        <= (alu_d[DATA_W-1:0] == '0);
                    state_q     <= run_i ? S_T0 : S_IDLE;
                    if (!run_i) pc_q <= '0;
                end
                S_HALT: begin
                    if (prog_we_i) ram_q[prog_addr_i] <= prog_data_i;
                    if (!run_i) begin
                        state_q <= S_IDLE;
                        pc_q    <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_data_o  = out_q;
    assign out_valid_o = out_valid_q;
    assign halted_o    = (state_q == S_HALT);
    assign cf_o        = cf_q;
    assign zf_o        = zf_q;
    assign pc_dbg_o    = pc_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_param_sap_cpu.sv
// Testbench for param_sap_cpu: directed programs plus random programs checked against an instruction-level model.
module tb_param_sap_cpu;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_i = 1'b0;
    logic          prog_we_i = 1'b0;
    logic [AW-1:0] prog_addr_i = '0;
    logic [DW-1:0] prog_data_i = '0;
    logic [DW-1:0] out_data_o;
    logic          out_valid_o, halted_o, cf_o, zf_o;
    logic [AW-1:0] pc_dbg_o;
    logic [2:0]    state_dbg_o;
`ifdef SINGLE_STEP_EN
    logic          step_i = 1'b0;
`endif

    param_sap_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
        .step_i(step_i),
`endif
        .run_i(run_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .halted_o(halted_o),
        .cf_o(cf_o), .zf_o(zf_o), .pc_dbg_o(pc_dbg_o), .state_dbg_o(state_dbg_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-level reference machine.
    logic [7:0] m_mem [16];
    logic [7:0] m_a, m_out;
    logic [3:0] m_pc;
    logic       m_cf, m_zf, m_halt, m_outv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_a = 0; m_out = 0; m_pc = 0; m_cf = 0; m_zf = 0; m_halt = 0; m_outv = 0;
    endtask

    // Executes one instruction; returns its cycle count.
    task automatic model_exec(output int cyc);
        logic [7:0] w;
        logic [3:0] opc, opr;
        int s;
        w = m_mem[m_pc];
        opc = w[7:4];
        opr = w[3:0];
        m_pc = m_pc + 4'd1;
        m_outv = 0;
        cyc = 3;
        case (opc)
            4'h1: begin m_a = m_mem[opr]; cyc = 4; end
            4'h2: begin
                s = int'(m_a) + int'(m_mem[opr]);
                m_cf = (s > 255); m_a = s[7:0]; m_zf = (m_a == 0); cyc = 5;
            end
            4'h3: begin
                m_cf = (m_a >= m_mem[opr]); m_a = m_a - m_mem[opr]; m_zf = (m_a == 0); cyc = 5;
            end
            4'h4: begin m_mem[opr] = m_a; cyc = 4; end
            4'h5: m_a = {4'h0, opr};
            4'h6: m_pc = opr;
            4'h7: if (m_cf) m_pc = opr;
            4'h8: if (m_zf) m_pc = opr;
            4'hE: begin m_out = m_a; m_outv = 1; end
            4'hF: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run_i = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        prog_we_i = 1'b1;
        prog_addr_i = addr;
        prog_data_i = data;
        m_mem[addr] = data;
        @(negedge clk);
        prog_we_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (state_dbg_o == s) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Runs the loaded program in lockstep with the model, then drops run and expects IDLE with PC=0.
    task automatic run_lockstep(input int max_instr, input string tag);
        int cyc;
        run_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < max_instr; i++) begin
            check({tag, " state@T0"}, 32'(state_dbg_o), 32'd1);
            check({tag, " pc"}, 32'(pc_dbg_o), 32'(m_pc));
            check({tag, " cf"}, 32'(cf_o), 32'(m_cf));
            check({tag, " zf"}, 32'(zf_o), 32'(m_zf));
            check({tag, " out_valid"}, 32'(out_valid_o), 32'(m_outv));
            check({tag, " out_data"}, 32'(out_data_o), 32'(m_out));
            model_exec(cyc);
            repeat (cyc) @(negedge clk);
            if (m_halt) begin
                check({tag, " halted"}, 32'(halted_o), 32'd1);
                break;
            end
        end
        run_i = 1'b0;
        wait_state(3'd0, 12, {tag, " return to idle"});
        check({tag, " idle pc"}, 32'(pc_dbg_o), 32'd0);
    endtask

    initial begin
        int cnt;
        bit seen;
        int t3s;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset state", 32'(state_dbg_o), 32'd0);
        check("reset outputs", {out_data_o, out_valid_o, halted_o, cf_o, zf_o, pc_dbg_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef SINGLE_STEP_EN
        // Test 1: LDA 14, ADD 15, OUT, HLT.
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'h05); load(4'd15, 8'h03);
        run_i = 1'b1;
        @(posedge clk);
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
            if (out_valid_o) seen = 1;
        end
        check("t1 out_valid latency", 32'(cnt), 32'd12);
        check("t1 out_data", 32'(out_data_o), 32'h08);
        @(posedge clk);
        #1;
        check("t1 out_valid single pulse", 32'(out_valid_o), 32'd0);
        @(negedge clk);
        wait_state(3'd6, 10, "t1 reach halt");
        check("t1 halted", 32'(halted_o), 32'd1);
        check("t1 flags", {cf_o, zf_o}, 32'd0);
        run_i = 1'b0;
        wait_state(3'd0, 4, "t1 halt to idle");

        // Test 2: 0xFF + 0x01 then JZ 9 (taken).
        do_reset();
        load(4'd0, 8'h1D); load(4'd1, 8'h2E); load(4'd2, 8'h89);
        load(4'd9, 8'hE0); load(4'd10, 8'hF0); load(4'd13, 8'hFF); load(4'd14, 8'h01);
        run_lockstep(10, "t2");
        check("t2 result", 32'(out_data_o), 32'h00);
        check("t2 flags", {cf_o, zf_o}, 32'b11);

        // Test 3: 0x03 - 0x05 then JC 9 (not taken).
        do_reset();
        load(4'd0, 8'h1D); load(4'd1, 8'h3E); load(4'd2, 8'h79);
        load(4'd3, 8'hE0); load(4'd4, 8'hF0); load(4'd13, 8'h03); load(4'd14, 8'h05);
        run_lockstep(10, "t3");
        check("t3 result", 32'(out_data_o), 32'hFE);
        check("t3 flags", {cf_o, zf_o}, 32'b00);

        // LDI / STA / LDA round trip.
        do_reset();
        load(4'd0, 8'h59); load(4'd1, 8'h4C); load(4'd2, 8'h50);
        load(4'd3, 8'h1C); load(4'd4, 8'hE0); load(4'd5, 8'hF0);
        run_lockstep(10, "sta");
        check("sta result", 32'(out_data_o), 32'h09);

        // Test 4: JMP 15 onto a NOP, PC wraps to 0.
        do_reset();
        load(4'd0, 8'h57); load(4'd1, 8'h6F);
        run_lockstep(7, "t4");

        // Test 5: reset asserted in T3 of an ADD.
        do_reset();
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd5, 8'h5A); load(4'd14, 8'h05); load(4'd15, 8'h03);
        run_i = 1'b1;
        t3s = 0;
        for (int i = 0; i < 30 && t3s < 2; i++) begin
            @(negedge clk);
            if (state_dbg_o == 3'd4) t3s++;
        end
        check("t5 reached ADD T3", 32'(t3s), 32'd2);
        rst_n = 1'b0;
        run_i = 1'b0;
        #1;
        check("t5 state", 32'(state_dbg_o), 32'd0);
        check("t5 outputs", {out_data_o, out_valid_o, halted_o, cf_o, zf_o, pc_dbg_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        load(4'd0, 8'h15); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
        run_lockstep(6, "t5 after reset");
        check("t5 ram cleared", 32'(out_data_o), 32'h00);

        // Random programs against the model.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int a = 0; a < 16; a++) load(4'(a), 8'($urandom));
            run_lockstep(25, "rnd");
        end
`else
        // Test 6: single-step gating.
        do_reset();
        for (int a = 0; a < 4; a++) load(4'(a), 8'h00);
        run_i = 1'b1;
        repeat (20) @(negedge clk);
        check("t6 pc before step", 32'(pc_dbg_o), 32'd0);
        check("t6 state before step", 32'(state_dbg_o), 32'd1);
        step_i = 1'b1;
        repeat (3) @(negedge clk);
        step_i = 1'b0;
        repeat (15) @(negedge clk);
        check("t6 pc after step", 32'(pc_dbg_o), 32'd1);
        check("t6 state after step", 32'(state_dbg_o), 32'd1);
        run_i = 1'b0;
        wait_state(3'd0, 4, "t6 idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
